rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port (write enable, write address, write data) between two requesters:
  - the in-order pipeline WB stage, which has priority and no backpressure;
  - the long-latency multiply/divide unit (MDU), which uses a valid/ready handshake.
- Buffers MDU results that lose arbitration.
- Keeps a 32-entry pending scoreboard and raises a hazard stall toward decode.
- Sits between WB/MDU and the register file, driving its write port at posedge.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width.
- BUF_DEPTH, 2, MDU result holding FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive starved cycles before a forced drain.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pipe_wen  in  1  WB-stage write request.
- pipe_waddr  in  AW  WB destination.
- pipe_wdata  in  XLEN  WB data.
- wb_stall  out  1  WB must hold and re-present this cycle's request.
- mdu_valid  in  1  MDU result valid.
- mdu_waddr  in  AW  MDU destination.
- mdu_wdata  in  XLEN  MDU data.
- mdu_ready  out  1  result accepted when mdu_valid & mdu_ready.
- issue_valid  in  1  decode issues an instruction.
- issue_long  in  1  issued instruction is an MDU op.
- issue_rd  in  AW  issued destination.
- dec_rs1  in  AW  decode source 1.
- dec_rs2  in  AW  decode source 2.
- hazard_stall  out  1  decode must stall.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- pending  out  32  scoreboard vector (debug).

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, pending=0, starve counter=0.
  - wb_stall=0, hazard_stall=0, mdu_ready=1 after release.
- rf_* are registered. A grant in cycle N appears on rf_* in cycle N+1. rf_we is high for exactly one cycle per grant.
- Writes to x0 are never granted and never consume the port. pipe_wen with pipe_waddr=0 counts as no request.
- mdu_ready = FIFO not full (registered count; no same-cycle pop credit). A handshake pushes {addr,data} at the clock edge.
- MDU results with mdu_waddr=0 are accepted and discarded, not pushed.
- Arbitration per cycle:
  - if wb_stall=1: grant FIFO head;
  - else if pipe request: grant pipe;
  - else if FIFO non-empty: grant FIFO head;
  - else: no grant.
- Starve counter:
  - increments while FIFO non-empty and the pipe wins;
  - clears on any FIFO grant or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- wb_stall = (counter == STARVE_LIMIT) & FIFO non-empty, decoded from registered state. In that cycle pipe_wen is ignored and the WB stage holds.
- Without bypass, MDU latency from handshake to rf_we is 2 cycles (push at N, grant at N+1, rf_we at N+2).
- Scoreboard:
  - set pending[issue_rd] when issue_valid & issue_long & issue_rd≠0;
  - clear pending[addr] when a FIFO (or bypass) grant occurs;
  - set and clear on the same index in the same cycle: set wins;
  - pending[0] is always 0.
- hazard_stall (combinational) = pending[dec_rs1] | pending[dec_rs2] | (issue_long & pending[issue_rd]). The last term is the WAW guard.
- Simultaneous FIFO push and pop: legal. Count is unchanged and ordering is preserved.
- Reset mid-operation: buffered results are discarded and pending is cleared. The MDU is reset by the same rst.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: when mdu handshake occurs, FIFO empty, no pipe request and wb_stall=0, the MDU result is granted directly, skipping the FIFO. Latency drops to 1 cycle (rf_we at N+1) and pending is cleared at that grant.
- Undefined: every MDU result passes through the FIFO; latency is 2 cycles minimum.

Test Plan:
- Reset: assert rst mid-cycle with FIFO holding 1 entry → rf_we=0, pending=0, FIFO empty immediately. After release, mdu_ready=1.
- Pipe only: pipe_wen=1, waddr=5, wdata=0xDEADBEEF in cycle N → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1. Repeat with waddr=0 → rf_we stays 0.
- MDU latency: issue_long rd=7 → pending[7]=1 and hazard_stall=1 for dec_rs1=7. mdu_valid waddr=7 data=0x1234 at N, no pipe traffic → rf_we at N+2, or N+1 with RF_WB_BYPASS_EN. pending[7]=0 after the grant.
- Contention/starvation: FIFO holds 1 entry and pipe_wen=1 every cycle, STARVE_LIMIT=4 → pipe wins 4 cycles, then wb_stall=1 for one cycle. The FIFO entry is written and the held pipe request is written the following cycle.
- Full FIFO: 2 MDU results pushed while the pipe writes continuously → mdu_ready=0 with 2 entries held. Entries drain in order, and mdu_ready returns to 1 the cycle after the first pop.
- Set/clear collision: FIFO grant for x9 in the same cycle as issue_long rd=9 → pending[9] remains 1.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
// Shares the single register-file write port between the in-order WB stage
// (priority, no backpressure) and the multiply/divide unit (valid/ready).
// MDU results that lose arbitration wait in a small holding FIFO. A starve
// counter forces a FIFO drain by stalling WB when the MDU has been locked out
// too long. A 32-entry pending scoreboard tracks in-flight MDU destinations
// and raises a hazard stall toward decode.
//
// Optional feature macro: RF_WB_BYPASS_EN
//   defined   - an MDU result that finds the port idle and the FIFO empty is
//               written directly (1-cycle latency).
//   undefined - every MDU result goes through the FIFO (2-cycle latency).
//
// Ports:
//   clk, rst                          clock (rising) / async active-high reset
//   pipe_wen/pipe_waddr/pipe_wdata    WB-stage write request
//   wb_stall                          WB must hold and re-present its request
//   mdu_valid/mdu_waddr/mdu_wdata     MDU result, accepted when mdu_ready=1
//   mdu_ready                         holding FIFO has room
//   issue_valid/issue_long/issue_rd   decode issue info (scoreboard set)
//   dec_rs1/dec_rs2                   decode sources for hazard check
//   hazard_stall                      decode must stall
//   rf_we/rf_waddr/rf_wdata           registered register-file write port
//   pending                           scoreboard vector (debug)
module rf_wb_scheduler #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wen,
  input  logic [AW-1:0]   pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  output logic            wb_stall,
  input  logic            mdu_valid,
  input  logic [AW-1:0]   mdu_waddr,
  input  logic [XLEN-1:0] mdu_wdata,
  output logic            mdu_ready,
  input  logic            issue_valid,
  input  logic            issue_long,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  output logic            hazard_stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pending
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and state
  logic [AW-1:0]   addr_mem_q [BUF_DEPTH];
  logic [XLEN-1:0] data_mem_q [BUF_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            wb_stall_s;
  logic            pipe_req_s;
  logic            mdu_hs_s;
  logic            push_s;
  logic            fifo_grant_s;
  logic            pipe_grant_s;
  logic            byp_grant_s;
  logic [AW-1:0]   head_addr_s;
  logic [XLEN-1:0] head_data_s;

  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign fifo_full_s  = (count_q == CW'(BUF_DEPTH));
  assign head_addr_s  = addr_mem_q[rd_ptr_q];
  assign head_data_s  = data_mem_q[rd_ptr_q];

  // Ready comes from registered occupancy only; a pop this cycle does not
  // free a slot until the next cycle.
  assign mdu_ready  = ~fifo_full_s;
  assign mdu_hs_s   = mdu_valid & ~fifo_full_s;
  assign wb_stall_s = (starve_q == SW'(STARVE_LIMIT)) & ~fifo_empty_s;
  assign wb_stall   = wb_stall_s;
  // A request to x0 is treated as no request; a stalled WB is ignored.
  assign pipe_req_s = pipe_wen & (pipe_waddr != {AW{1'b0}}) & ~wb_stall_s;

  // Port arbitration: forced drain, then WB, then FIFO, then optional bypass.
  always_comb begin
    fifo_grant_s = 1'b0;
    pipe_grant_s = 1'b0;
    byp_grant_s  = 1'b0;
    if (wb_stall_s) begin
      fifo_grant_s = 1'b1;
    end else if (pipe_req_s) begin
      pipe_grant_s = 1'b1;
    end else if (!fifo_empty_s) begin
      fifo_grant_s = 1'b1;
    end else begin
`ifdef RF_WB_BYPASS_EN
      byp_grant_s = mdu_hs_s & (mdu_waddr != {AW{1'b0}});
`else
      byp_grant_s = 1'b0;
`endif
    end
  end

  // x0 results are accepted but dropped; bypassed results skip the FIFO.
  assign push_s = mdu_hs_s & (mdu_waddr != {AW{1'b0}}) & ~byp_grant_s;

  // FIFO pointer and occupancy next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (fifo_grant_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, fifo_grant_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starve counter: counts pipe wins over a waiting FIFO, saturating.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty_s || fifo_grant_s) begin
      starve_d = {SW{1'b0}};
    end else if (pipe_grant_s && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Scoreboard: clear on MDU-result grant, then set on long issue (set wins).
  always_comb begin
    pending_d = pending_q;
    if (fifo_grant_s) begin
      pending_d[head_addr_s] = 1'b0;
    end else if (byp_grant_s) begin
      pending_d[mdu_waddr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_valid && issue_long && (issue_rd != {AW{1'b0}})) begin
      pending_d[issue_rd] = 1'b1;
    end else begin
      pending_d[issue_rd] = pending_d[issue_rd];
    end
    pending_d[0] = 1'b0;
  end

  // Write-port next state from the granted source
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (fifo_grant_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr_s;
      rf_wdata_d = head_data_s;
    end else if (pipe_grant_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (byp_grant_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mdu_waddr;
      rf_wdata_d = mdu_wdata;
    end else begin
      rf_we_d    = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      starve_q   <= {SW{1'b0}};
      pending_q  <= 32'h0000_0000;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {AW{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO payload storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= mdu_waddr;
      data_mem_q[wr_ptr_q] <= mdu_wdata;
    end
  end

  assign hazard_stall = pending_q[dec_rs1] | pending_q[dec_rs2] |
                        (issue_long & pending_q[issue_rd]);

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pending  = pending_q;

endmodule
